// File: rtl/sha3_pad_stream.sv
// SHA3 domain padder: turns a byte-granular AXI-Stream message into rate-sized padded blocks.
// Optional `SHA3_PAD_LEN_CNT_EN adds a MSG_BYTES message length counter output.
module sha3_pad_stream #(
  parameter int WIDTH = 16
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic [WIDTH-1:0]   S_TDATA,
  input  logic [WIDTH/8-1:0] S_TKEEP,
  input  logic               S_TVALID,
  output logic               S_TREADY,
  input  logic               S_TLAST,
  input  logic [1:0]         S_TUSER,
  output logic [WIDTH-1:0]   M_TDATA,
  output logic               M_TVALID,
  input  logic               M_TREADY,
  output logic               M_TLAST,
  output logic               M_TID,
  output logic [1:0]         M_TUSER
`ifdef SHA3_PAD_LEN_CNT_EN
  ,output logic [31:0]       MSG_BYTES
`endif
);

  localparam int LANES = WIDTH / 8;

  typedef enum logic [1:0] {IDLE, PASS, PAD_START, PAD} state_t;

  state_t           state_q, state_d;
  logic [7:0]       wc_q, wc_d;
  logic [1:0]       mode_q, mode_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_id_q, out_id_d;
  logic [1:0]       out_user_q, out_user_d;

  logic       load;
  logic       s_ready;
  logic [1:0] cur_mode;
  logic       at_end;
  int         k;

  function automatic logic [7:0] rate_m1(input logic [1:0] mode);
    case (mode)
      2'd0:    return 8'(1152 / WIDTH - 1);
      2'd1:    return 8'(1088 / WIDTH - 1);
      2'd2:    return 8'(832 / WIDTH - 1);
      default: return 8'(576 / WIDTH - 1);
    endcase
  endfunction

  // Lanes below k keep data, lane k gets the 0x06 domain byte, final lane may take the 0x80 pad end.
  function automatic logic [WIDTH-1:0] pad_word(input logic [WIDTH-1:0] data, input int kk,
                                                input logic fin);
    logic [WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < kk)       w[WIDTH-1-8*i -: 8] = data[WIDTH-1-8*i -: 8];
      else if (i == kk) w[WIDTH-1-8*i -: 8] = 8'h06;
    end
    if (fin) w[7:0] = w[7:0] | 8'h80;
    return w;
  endfunction

  assign load     = !out_valid_q || M_TREADY;
  assign s_ready  = (state_q == IDLE || state_q == PASS) && load && !ARESET;
  assign cur_mode = (state_q == IDLE) ? S_TUSER : mode_q;
  assign at_end   = (wc_q == rate_m1(cur_mode));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    k = 0;
    for (int i = 0; i < LANES; i++) begin
      if (S_TKEEP[i]) k = k + 1;
    end
  end

  always_comb begin
    state_d     = state_q;
    wc_d        = wc_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_id_d    = out_id_q;
    out_user_d  = out_user_q;

    if (load) begin
      out_valid_d = 1'b0;
      case (state_q)
        IDLE, PASS: begin
          if (S_TVALID) begin
            out_valid_d = 1'b1;
            out_user_d  = cur_mode;
            mode_d      = cur_mode;
            out_id_d    = 1'b0;
            if (!S_TLAST || k == LANES) begin
              out_data_d = S_TDATA;
              out_last_d = at_end;
              wc_d       = at_end ? 8'd0 : wc_q + 8'd1;
              state_d    = S_TLAST ? PAD_START : PASS;
            end else begin
              out_data_d = pad_word(S_TDATA, k, at_end);
              out_last_d = at_end;
              out_id_d   = at_end;
              wc_d       = at_end ? 8'd0 : wc_q + 8'd1;
              state_d    = at_end ? IDLE : PAD;
            end
          end
        end
        PAD_START, PAD: begin
          out_valid_d = 1'b1;
          out_data_d  = pad_word('0, (state_q == PAD_START) ? 0 : LANES, at_end);
          out_last_d  = at_end;
          out_id_d    = at_end;
          wc_d        = at_end ? 8'd0 : wc_q + 8'd1;
          state_d     = at_end ? IDLE : PAD;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= IDLE;
      wc_q        <= '0;
      mode_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_id_q    <= 1'b0;
      out_user_q  <= '0;
    end else begin
      state_q     <= state_d;
      wc_q        <= wc_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_id_q    <= out_id_d;
      out_user_q  <= out_user_d;
    end
  end

`ifdef SHA3_PAD_LEN_CNT_EN
  logic [31:0] msg_bytes_q, msg_bytes_d;

  always_comb begin
    msg_bytes_d = msg_bytes_q;
    if (S_TVALID && s_ready) begin
      msg_bytes_d = (state_q == IDLE) ? 32'(k) : msg_bytes_q + 32'(k);
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) msg_bytes_q <= '0;
    else        msg_bytes_q <= msg_bytes_d;
  end

  assign MSG_BYTES = msg_bytes_q;
`endif

  assign S_TREADY = s_ready;
  assign M_TVALID = out_valid_q;
  assign M_TDATA  = out_data_q;
  assign M_TLAST  = out_last_q;
  assign M_TID    = out_id_q;
  assign M_TUSER  = out_user_q;

endmodule

// File: doc/sha3_pad_stream.md
Name: sha3_pad_stream

Overview:
- Upstream feeder for the AXI-Stream SHA3 core.
- Accepts a byte-granular message as a WIDTH-bit AXI-Stream and applies SHA3 domain padding (0x06 … 0x80, pad10*1).
- Emits rate-sized blocks of WIDTH-bit words, marking block ends and the final block of each message.
- The SHA3 core downstream no longer needs software-side padding or last-block signalling.

Parameters:
WIDTH, 16, stream word width in bits; multiple of 8, divides 576; byte lane 0 = bits [WIDTH-1:WIDTH-8] (first byte in the MSBs)

Ports:
ACLK  in  1  clock, rising edge
ARESET  in  1  asynchronous reset, active-high
S_TDATA  in  WIDTH  message data
S_TKEEP  in  WIDTH/8  byte-valid mask, contiguous from lane 0; all-ones except on the S_TLAST beat; may be all-zero on the S_TLAST beat
S_TVALID  in  1  input valid
S_TREADY  out  1  input ready
S_TLAST  in  1  last beat of message
S_TUSER  in  2  mode: 0=SHA3-224, 1=-256, 2=-384, 3=-512; sampled on first beat of a message
M_TDATA  out  WIDTH  padded block word
M_TVALID  out  1  output valid
M_TREADY  in  1  output ready
M_TLAST  out  1  last word of a rate block
M_TID  out  1  1 only on the M_TLAST word of the message's final block
M_TUSER  out  2  mode latched for the current message

Behaviour:
- Rate R (words) = rate_bits/WIDTH, with rate_bits 1152/1088/832/576 for modes 0/1/2/3. For WIDTH=16, R = 72/68/52/36.
- Reset (async, ARESET=1):
  - M_TVALID=0, M_TDATA=0, M_TLAST=0, M_TID=0, M_TUSER=0, S_TREADY=0.
  - state=IDLE, word counter wc=0.
- Single registered output stage:
  - Latency 1 cycle from input handshake to M_TVALID.
  - Output register loads when !M_TVALID || M_TREADY.
  - M_TDATA/M_TLAST/M_TID/M_TUSER are stable while M_TVALID && !M_TREADY.
- S_TREADY = (state==IDLE || state==PASS) && (!M_TVALID || M_TREADY) && !ARESET. Combinational; no path from S_TVALID.
- FSM:
  - IDLE: first accepted beat latches mode from S_TUSER. If S_TLAST=0, go to PASS; if S_TLAST=1, handle as last beat.
  - PASS, non-last beat: word forwarded unchanged. M_TLAST=(wc==R-1). wc wraps to 0 after R-1, otherwise increments.
  - PASS/IDLE, last beat with k = popcount(S_TKEEP):
    - k<WIDTH/8: lanes <k carry data, lane k=0x06, lanes >k=0x00.
    - k<WIDTH/8 and wc==R-1: lane WIDTH/8-1 |= 0x80 (0x86 if k==WIDTH/8-1). Word has M_TLAST=1, M_TID=1; go to IDLE.
    - k<WIDTH/8 and wc<R-1: go to PAD.
    - k==WIDTH/8: word forwarded unchanged with M_TLAST=(wc==R-1), M_TID=0; go to PAD_START.
  - PAD_START: emit word with lane 0=0x06, others 0x00.
    - If this is the block's last word, lane WIDTH/8-1 |= 0x80 and M_TLAST=M_TID=1; go to IDLE.
    - Otherwise go to PAD.
  - PAD: emit 0x00 words until wc==R-1; that word = 0x00..0x80 with M_TLAST=1, M_TID=1; go to IDLE.
  - S_TREADY=0 in PAD_START/PAD. Padded words advance only on output-stage load.
- Boundary cases:
  - Message ending exactly on a block boundary: produces one additional all-padding block.
  - Empty message (first beat has S_TLAST, S_TKEEP=0): one full padding block.
- Mode: S_TUSER changes mid-message are ignored.
- Reset mid-operation: all state and any in-flight words are discarded immediately.

Optional Feature:
SHA3_PAD_LEN_CNT_EN:
- Defined: adds output port MSG_BYTES [31:0], reset 0.
  - On first beat of a message: cleared to that beat's k.
  - On each subsequent accepted beat: increments by k.
  - Holds after the message until the next first beat; wraps modulo 2^32.
- Undefined: port and counter are absent; no other behaviour changes.

Test Plan:
- Empty message, mode 0: one beat S_TLAST=1, S_TKEEP=00 -> 72 words: word0=0x0600, words1..70=0x0000, word71=0x0080 with M_TLAST=1, M_TID=1.
- "abc", mode 1: beats 0x6162 keep 11, then 0x63xx keep 10 with last -> 68 words: 0x6162, 0x6306, 0x0000×65, then 0x0080 with M_TLAST=1, M_TID=1.
- Block-aligned, mode 3: 36 full beats, last on beat 36 -> block 1 = data with word35 M_TLAST=1, M_TID=0; block 2 = 0x0600, 0x0000×34, 0x0080 with M_TLAST=1, M_TID=1.
- 0x86 merge, mode 3: 35 full beats, then beat 36 = 0xABxx keep 10 with last -> word35=0xAB86 with M_TLAST=1, M_TID=1; no extra block.
- Backpressure: "abc" with M_TREADY toggling pseudo-randomly -> identical 68-word sequence; outputs held stable while M_TVALID && !M_TREADY; S_TREADY=0 throughout PAD.
- Reset mid-message: ARESET pulsed during PAD of a mode-2 message -> M_TVALID=0 immediately. Following "abc" mode-2 message produces a correct 52-word block; with SHA3_PAD_LEN_CNT_EN, MSG_BYTES=3.
